// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, state encoding and instruction field positions for the multicycle core
package cpu_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD, OP_STORE, OP_JZ
  } opcode_t;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
  } state_t;
  localparam int OP_LSB = 29;
  localparam int RA_LSB = 24;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 14;
  localparam int ADDR_W = 16;
  function automatic logic writes_reg(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_LOAD);
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREG x DATA_W registers, three async read ports, one sync write port, R0 fixed at 0
module cpu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RW-1:0]     addr_a,
  input  logic [RW-1:0]     addr_b,
  input  logic [RW-1:0]     addr_c,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] data_c,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] r [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) r[i] <= '0;
    else if (we && waddr != '0) r[waddr] <= wdata;
  assign data_a = addr_a == '0 ? '0 : r[addr_a];
  assign data_b = addr_b == '0 ? '0 : r[addr_b];
  assign data_c = addr_c == '0 ? '0 : r[addr_c];
endmodule

// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: five-state fetch/decode/execute/memory/writeback CPU with req/ack memories
module multicycle_cpu_core import cpu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int PC_W = 16,
  parameter int DADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         state,
  output logic               retire
);
  localparam int RW = $clog2(NREG);
  state_t            st;
  opcode_t           op;
  logic [31:0]       ir;
  logic [RW-1:0]     rd;
  logic [PC_W-1:0]   tgt;
  logic [DATA_W-1:0] opa, opb, opc, res, rf_a, rf_b, rf_c, alu;
  logic              ihold;
  cpu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .addr_a(ir[RA_LSB +: RW]), .addr_b(ir[RB_LSB +: RW]), .addr_c(ir[RC_LSB +: RW]),
    .data_a(rf_a), .data_b(rf_b), .data_c(rf_c),
    .we(retire && writes_reg(op)), .waddr(rd), .wdata(res)
  );
  // ihold keeps a started fetch requesting even if run drops before the ack
  assign imem_req = rst_n && st == S_FETCH && (run || ihold);
  assign imem_addr = pc;
  assign dmem_req = st == S_MEMORY && (op == OP_LOAD || op == OP_STORE);
  assign dmem_we = dmem_req && op == OP_STORE;
  assign retire = st == S_WRITEBACK;
  assign state = st;
  always_comb
    alu = op == OP_ADD ? opb + opc :
          op == OP_SUB ? opb - opc :
          op == OP_AND ? opb & opc : opb | opc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= S_FETCH;
      pc <= '0;
      ir <= '0;
      ihold <= 1'b0;
      op <= OP_NOP;
      rd <= '0;
      tgt <= '0;
      opa <= '0;
      opb <= '0;
      opc <= '0;
      res <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
    end else
      case (st)
        S_FETCH:
          if (imem_req) begin
            ihold <= !imem_ack;
            if (imem_ack) begin
              ir <= imem_rdata;
              pc <= pc + 1'b1;
              st <= S_DECODE;
            end
          end
        S_DECODE: begin
          op <= opcode_t'(ir[OP_LSB +: 3]);
          rd <= ir[RA_LSB +: RW];
          tgt <= ir[PC_W-1:0];
          opa <= rf_a;
          opb <= rf_b;
          opc <= rf_c;
          dmem_addr <= ir[DADDR_W-1:0];
          dmem_wdata <= rf_a;
          st <= S_EXECUTE;
        end
        S_EXECUTE: begin
          res <= alu;
          if (op == OP_JZ && opa == '0) pc <= tgt;
          st <= S_MEMORY;
        end
        S_MEMORY:
          if (!dmem_req || dmem_ack) begin
            if (dmem_req && !dmem_we) res <= dmem_rdata;
            st <= S_WRITEBACK;
          end
        default: st <= S_FETCH;
      endcase
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core: directed program vectors plus handshake, reset and wrap sequences
module tb_multicycle_cpu_core;
  import cpu_pkg::*;
  logic clk = 0, rst_n = 0, run = 0, run2 = 0;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire;
  logic [15:0] imem_addr, dmem_addr, pc;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
  logic [2:0]  state;

  logic        imem_req2, dmem_req2, dmem_we2, retire2;
  logic [3:0]  imem_addr2, pc2;
  logic [15:0] dmem_addr2;
  logic [31:0] dmem_wdata2;
  logic [2:0]  state2;

  multicycle_cpu_core dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .state(state), .retire(retire)
  );
  multicycle_cpu_core #(.PC_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(32'd0),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_ack(1'b0), .dmem_rdata(32'd0), .pc(pc2), .state(state2), .retire(retire2)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int iwait, dwait, icnt, dcnt;
  assign imem_ack = imem_req && icnt >= iwait;
  assign dmem_ack = dmem_req && dcnt >= dwait;
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
  end

  int fetch_n, wr_n, fetch2_n;
  logic [15:0] flog [64];
  logic [3:0]  flog2 [64];
  logic [15:0] last_a;
  logic [31:0] last_d;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_n <= 0; wr_n <= 0; fetch2_n <= 0; last_a <= 0; last_d <= 0;
    end else begin
      if (imem_req && imem_ack) begin
        if (fetch_n < 64) flog[fetch_n[5:0]] <= imem_addr;
        fetch_n <= fetch_n + 1;
      end
      if (imem_req2) begin
        if (fetch2_n < 64) flog2[fetch2_n[5:0]] <= imem_addr2;
        fetch2_n <= fetch2_n + 1;
      end
      if (dmem_req && dmem_ack && dmem_we) begin
        wr_n <= wr_n + 1; last_a <= dmem_addr; last_d <= dmem_wdata;
      end
    end

  int nvec = 0, nbad = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [2:0] o, input logic [4:0] a, b, c);
    return {o, a, b, c, 14'b0};
  endfunction
  function automatic logic [31:0] mi(input logic [2:0] o, input logic [4:0] a, input logic [15:0] ad);
    return {o, a, 8'b0, ad};
  endfunction

  task automatic do_reset();
    run = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_prog(input logic [31:0] p0, p1, p2, p3);
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    imem[0] = p0; imem[1] = p1; imem[2] = p2; imem[3] = p3;
  endtask

  typedef struct {
    logic [31:0] p0, p1, p2, p3;
    int n, iw, dw;
    logic [15:0] f2, pc;
    int wr;
    logic [15:0] a;
    logic [31:0] d;
    int cyc;
  } vec_t;
  vec_t vt [8];

  task automatic run_vec(input int k, input vec_t v);
    int cyc, r;
    load_prog(v.p0, v.p1, v.p2, v.p3);
    iwait = v.iw; dwait = v.dw;
    do_reset();
    run = 1;
    cyc = 0; r = 0;
    while (r < v.n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (retire) r++;
    end
    @(negedge clk);
    cyc++;
    run = 0;
    chk($sformatf("v%0d cycles", k), cyc, v.cyc);
    chk($sformatf("v%0d pc", k), pc, v.pc);
    chk($sformatf("v%0d fetch2", k), flog[2], v.f2);
    chk($sformatf("v%0d writes", k), wr_n, v.wr);
    chk($sformatf("v%0d waddr", k), last_a, v.a);
    chk($sformatf("v%0d wdata", k), last_d, v.d);
  endtask

  initial begin
    int cnt, bad, dcount, rc;
    for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
    dmem[8'h10] = 5; dmem[8'h11] = 7; dmem[8'h13] = 0; dmem[8'h14] = 1;
    dmem[8'h15] = 32'hF0F0F0F0; dmem[8'h16] = 32'h0FF00FF0;
    iwait = 0; dwait = 0;

    run = 1;
    #1;
    chk("rst imem_req", imem_req, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst dmem_we", dmem_we, 0);
    chk("rst retire", retire, 0);
    chk("rst state", state, 0);
    chk("rst pc", pc, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst dmem_wdata", dmem_wdata, 0);
    run = 0;

    vt[0] = '{mi(OP_LOAD,1,16'h10), mi(OP_LOAD,2,16'h11), rr(OP_ADD,3,1,2), mi(OP_STORE,3,16'h12),
              4, 0, 0, 16'h2, 16'h4, 1, 16'h12, 32'd12, 20};
    vt[1] = '{mi(OP_LOAD,1,16'h10), mi(OP_LOAD,2,16'h11), rr(OP_SUB,3,1,2), mi(OP_STORE,3,16'h20),
              4, 0, 0, 16'h2, 16'h4, 1, 16'h20, 32'hFFFFFFFE, 20};
    vt[2] = '{mi(OP_LOAD,1,16'h15), mi(OP_LOAD,2,16'h16), rr(OP_AND,3,1,2), mi(OP_STORE,3,16'h21),
              4, 0, 0, 16'h2, 16'h4, 1, 16'h21, 32'h00F000F0, 20};
    vt[3] = '{mi(OP_LOAD,1,16'h15), mi(OP_LOAD,2,16'h16), rr(OP_OR,3,1,2), mi(OP_STORE,3,16'h22),
              4, 0, 0, 16'h2, 16'h4, 1, 16'h22, 32'hFFF0FFF0, 20};
    vt[4] = '{mi(OP_LOAD,1,16'h10), mi(OP_LOAD,2,16'h11), rr(OP_ADD,0,1,2), mi(OP_STORE,0,16'h23),
              4, 0, 0, 16'h2, 16'h4, 1, 16'h23, 32'd0, 20};
    vt[5] = '{mi(OP_LOAD,4,16'h13), mi(OP_JZ,4,16'h20), mi(OP_STORE,4,16'h24), 32'd0,
              3, 0, 0, 16'h20, 16'h21, 0, 16'h0, 32'd0, 15};
    vt[6] = '{mi(OP_LOAD,4,16'h14), mi(OP_JZ,4,16'h20), mi(OP_STORE,4,16'h24), 32'd0,
              3, 0, 0, 16'h2, 16'h3, 1, 16'h24, 32'd1, 15};
    vt[7] = '{mi(OP_LOAD,1,16'h10), mi(OP_STORE,1,16'h25), 32'd0, 32'd0,
              3, 3, 2, 16'h2, 16'h3, 1, 16'h25, 32'd5, 28};
    for (int k = 0; k < 8; k++) run_vec(k, vt[k]);

    // reset in the middle of a stalled data access
    load_prog(mi(OP_LOAD,1,16'h10), 32'd0, 32'd0, 32'd0);
    iwait = 0; dwait = 50;
    do_reset();
    run = 1;
    cnt = 0;
    while (!dmem_req && cnt < 20) begin @(negedge clk); cnt++; end
    chk("midrst dmem_req seen", dmem_req, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst dmem_req", dmem_req, 0);
    chk("midrst pc", pc, 0);
    chk("midrst state", state, 0);
    chk("midrst imem_req", imem_req, 0);
    @(negedge clk);
    dwait = 0;
    rst_n = 1;
    #1;
    chk("midrst imem_req after", imem_req, 1);
    chk("midrst imem_addr after", imem_addr, 0);
    @(negedge clk);
    chk("midrst first fetch", flog[0], 0);
    run = 0;

    // wait states, with run dropped while the fetch is still pending
    load_prog(mi(OP_LOAD,1,16'h10), 32'd0, 32'd0, 32'd0);
    iwait = 3; dwait = 2;
    do_reset();
    run = 1;
    cnt = 0; dcount = 0; bad = 0; rc = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) run = 0;
      #1;
      cnt += int'(imem_req);
      dcount += int'(dmem_req);
      if (imem_req && imem_addr != 0) bad++;
      if (dmem_req && (dmem_addr != 16'h10 || dmem_we)) bad++;
      if (retire) rc = c;
      @(negedge clk);
    end
    chk("wait imem_req cycles", cnt, 4);
    chk("wait dmem_req cycles", dcount, 3);
    chk("wait unstable", bad, 0);
    chk("wait retire cycle", rc, 9);
    chk("wait state end", state, 0);
    @(negedge clk);
    chk("wait fetch count", fetch_n, 1);

    // idle with run low
    iwait = 0; dwait = 0;
    do_reset();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); cnt += int'(imem_req); end
    chk("idle imem_req", cnt, 0);
    chk("idle pc", pc, 0);
    chk("idle state", state, 0);

    // run dropped during EXECUTE
    load_prog(mi(OP_LOAD,1,16'h10), mi(OP_LOAD,2,16'h11), 32'd0, 32'd0);
    do_reset();
    run = 1;
    cnt = 0;
    while (state != 3'd2 && cnt < 10) begin @(negedge clk); cnt++; end
    run = 0;
    rc = 0; cnt = 0;
    while (!retire && cnt < 10) begin @(negedge clk); cnt++; end
    chk("drop retired", retire, 1);
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("drop fetch count", fetch_n, 1);
    chk("drop pc", pc, 1);
    chk("drop state", state, 0);

    // PC wrap on a 4-bit program counter
    do_reset();
    run2 = 1;
    cnt = 0;
    while (fetch2_n < 17 && cnt < 200) begin @(negedge clk); cnt++; end
    run2 = 0;
    chk("wrap fetches", fetch2_n >= 17, 1);
    chk("wrap addr0", flog2[0], 0);
    chk("wrap addr15", flog2[15], 15);
    chk("wrap addr16", flog2[16], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu_core.md
# multicycle_cpu_core

Parametrised five-state multicycle CPU core: the next generation of the team's fetch/decode/execute/memory CPU. It adds a writeback state, an asynchronous active-low reset, and a run enable. Instruction and data memories are external, behind req/ack handshakes that tolerate wait states. It is the top of the CPU subsystem and connects to instruction memory, data memory, and a testbench.

## Interface
Parameters:
- DATA_W, 32: register and data-memory word width.
- NREG, 32: number of registers; power of two, 2..32.
- PC_W, 16: program counter and instruction-address width.
- DADDR_W, 16: data-memory address width; must be at most 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable; sampled only in FETCH.
- imem_req  out  1  instruction read request.
- imem_addr  out  PC_W  instruction address; equals pc.
- imem_ack  in  1  instruction read complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  data access complete.
- dmem_rdata  in  DATA_W  load data; valid when dmem_ack is high.
- pc  out  PC_W  current program counter.
- state  out  3  current state encoding.
- retire  out  1  one-cycle pulse when an instruction completes.

## Operation
- Instruction format (fixed 32 bits):
  - opcode = [31:29]
  - ra = [28:24]
  - rb = [23:19]
  - rc = [18:14]
  - addr = [15:0]; addr overlaps rc and is used only by LOAD, STORE and JZ.
- Register fields use their low log2(NREG) bits.
- Opcodes:
  - 0 NOP: no operation.
  - 1 ADD: R[ra] = R[rb] + R[rc].
  - 2 SUB: R[ra] = R[rb] - R[rc].
  - 3 AND: R[ra] = R[rb] & R[rc].
  - 4 OR: R[ra] = R[rb] | R[rc].
  - 5 LOAD: R[ra] = mem[addr].
  - 6 STORE: mem[addr] = R[ra].
  - 7 JZ: if R[ra] == 0, pc = addr.
- Arithmetic is modulo 2^DATA_W; no flags, no traps. dmem_addr = addr[DADDR_W-1:0]. JZ target = addr[PC_W-1:0].
- R0 reads as 0; writes to R0 are discarded.
- State machine (encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4):
  - FETCH, run=0: idle with imem_req=0.
  - FETCH, run=1: assert imem_req. On the edge where imem_ack=1, latch the instruction, set pc = pc+1 (wraps to 0 after 2^PC_W-1), go to DECODE.
  - DECODE: latch opcode and fields; read R[rb], R[rc], R[ra] into operand registers. Go to EXECUTE.
  - EXECUTE: compute the ALU result into a result register. For JZ, overwrite pc with the target if the operand is 0. Go to MEMORY.
  - MEMORY, LOAD or STORE: assert dmem_req and hold until dmem_ack. LOAD latches dmem_rdata on the ack edge. Go to WRITEBACK.
  - MEMORY, other opcodes: one cycle, then WRITEBACK.
  - WRITEBACK: write R[ra] for opcodes 1–5. retire=1 for this cycle. Go to FETCH.
- run is checked only in FETCH; an instruction already in flight always completes.

## Timing
- Reset (async, immediate):
  - state=FETCH, pc=0, all registers 0.
  - imem_req=0, dmem_req=0, dmem_we=0, retire=0.
  - dmem_addr, dmem_wdata and the latched instruction = 0.
- A request is held with stable address and data until the ack edge. The request drops in the cycle after the ack.
- An ack may arrive in the first request cycle (zero wait). An ack while req=0 is ignored.
- With zero wait states, every instruction takes exactly 5 cycles, FETCH edge to FETCH.
- Each wait cycle on imem_ack or dmem_ack adds one cycle.
- Reset asserted mid-handshake drops req combinationally with rst_n; the transaction is abandoned.
- A register written in WRITEBACK is visible to the next instruction's DECODE.

## Structure
- Package cpu_pkg holds the opcode constants, the state encoding, and the instruction field bit positions.
- Sub-module cpu_regfile: NREG×DATA_W, three asynchronous read ports, one synchronous write port, async reset, R0 hardwired to 0.
- The ALU is inline combinational logic in the core.

## Test plan
- Reset during MEMORY with dmem_req=1 and rst_n pulled low: dmem_req=0 immediately, pc=0, state=0. After release with run=1, the first imem_addr is 0.
- Program LOAD R1,[0x10] (mem=5); LOAD R2,[0x11] (mem=7); ADD R3,R1,R2; STORE R3,[0x12], zero wait states: 4 retire pulses in 20 cycles; data write of 12 at 0x12.
- Wrap-around:
  - SUB R3,R1,R2 with 5−7, then STORE R3: stored value is 0xFFFFFFFE.
  - PC_W=4, straight-line NOPs: imem_addr sequence 15 then 0.
- Wait states: imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles on a LOAD. Both requests and addresses stay stable throughout; instruction latency is 10 cycles.
- JZ R4,0x0020:
  - R4=0: next imem_addr is 0x20.
  - R4=1: next imem_addr is old pc+1.
- Control and R0:
  - run=0 in FETCH: no imem_req, pc frozen.
  - run dropped during EXECUTE: the current instruction still retires.
  - ADD R0,R1,R2 then STORE R0: stored value is 0.
